// File: rtl/cmp_pkg.sv
// Shared sizing helpers for the clocked latching comparator array.
// Used by cmp_latch_array_if, cmp_channel and cmp_latch_array.
package cmp_pkg;

  // Width of the channel select bus; never narrower than one bit.
  function automatic int sel_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Width of the per-channel deglitch run counter; never narrower than one bit.
  function automatic int fcnt_w(input int filt_len);
    return (filt_len > 1) ? $clog2(filt_len) : 1;
  endfunction

  // Saturation value of a w-bit transition counter (all ones).
  function automatic longint unsigned cnt_sat(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Default counter width and its saturation point.
  localparam int              CNT_W_DEF = 8;
  localparam longint unsigned CNT_SAT   = cnt_sat(CNT_W_DEF);

endpackage : cmp_pkg

// File: rtl/cmp_latch_array_if.sv
// Pin-side bundle of the comparator array: enables, comparator inputs,
// counter controls and the decision/pulse/counter outputs.
// master = the block driving the comparator (pins / bench), slave = cmp_latch_array.
interface cmp_latch_array_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  import cmp_pkg::*;

  localparam int SW = sel_w(CHANNELS);

  logic                ena;
  logic [CHANNELS-1:0] vip;
  logic [CHANNELS-1:0] vin;
  logic                clr;
  logic [SW-1:0]       sel;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] chg;
  logic [CNT_W-1:0]    cnt_out;

  modport master (
    output ena, vip, vin, clr, sel,
    input  out, chg, cnt_out
  );

  modport slave (
    input  ena, vip, vin, clr, sel,
    output out, chg, cnt_out
  );

endinterface : cmp_latch_array_if

// File: rtl/cmp_channel.sv
// One comparator channel: 2-flop synchronisers on vip/vin, a run-length
// deglitch filter, the latched decision and its change pulse.
// The decision only moves toward vip_s when vip_s and vin_s disagree;
// when they agree the previous decision is held (latch behaviour).
module cmp_channel
  import cmp_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena_i,
  input  logic vip_i,
  input  logic vin_i,
  output logic out_o,
  output logic chg_o
);

  localparam int             FW        = fcnt_w(FILT_LEN);
  localparam logic [FW-1:0]  FCNT_LAST = FW'(FILT_LEN - 1);

  logic          vip_meta_q, vip_s_q;
  logic          vin_meta_q, vin_s_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          out_q, out_d;
  logic          chg_q, chg_d;
  logic          qual;

  // Two-stage synchronisers; these run regardless of ena.
  // NOTE: every clocked state update uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vip_meta_q <= 1'b0;
      vip_s_q    <= 1'b0;
      vin_meta_q <= 1'b0;
      vin_s_q    <= 1'b0;
    end else begin
      vip_meta_q <= vip_i;
      vip_s_q    <= vip_meta_q;
      vin_meta_q <= vin_i;
      vin_s_q    <= vin_meta_q;
    end
  end

  // A cycle qualifies when the pair disagrees and vip points away from the current decision.
  assign qual = (vip_s_q ^ vin_s_q) && (vip_s_q != out_q);

  // Filter next state: count qualifying cycles, flip after FILT_LEN in a row.
  // NOTE: defaults first so every path assigns every _d signal and no latch is inferred.
  always_comb begin
    fcnt_d = fcnt_q;
    out_d  = out_q;
    chg_d  = 1'b0;
    if (ena_i) begin
      if (!qual) begin
        fcnt_d = '0;
      end else if (fcnt_q == FCNT_LAST) begin
        out_d  = vip_s_q;
        fcnt_d = '0;
        chg_d  = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Filter, decision and change-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      out_q  <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      out_q  <= out_d;
      chg_q  <= chg_d;
    end
  end

  assign out_o = out_q;
  // The pulse is masked whenever the array is frozen.
  assign chg_o = chg_q & ena_i;

endmodule : cmp_channel

// File: rtl/cmp_latch_array.sv
// Multi-channel clocked latching comparator with deglitch, change pulses
// and (optionally) saturating per-channel transition counters.
// Build option: define CMP_EVCNT_EN to implement the transition counters,
// clr and cnt_out; without it cnt_out is tied to 0 and clr/sel are ignored.
module cmp_latch_array
  import cmp_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  cmp_latch_array_if.slave  bus
);

  localparam int SW = sel_w(CHANNELS);

  logic [CHANNELS-1:0] out_w;
  logic [CHANNELS-1:0] chg_w;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    cmp_channel #(
      .FILT_LEN (FILT_LEN)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ena_i (bus.ena),
      .vip_i (bus.vip[g]),
      .vin_i (bus.vin[g]),
      .out_o (out_w[g]),
      .chg_o (chg_w[g])
    );
  end

  assign bus.out = out_w;
  assign bus.chg = chg_w;

`ifdef CMP_EVCNT_EN

  localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_sat(CNT_W));

  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;

  // Counter next state: clr wins, otherwise a visible chg bumps the count until saturation.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.clr) begin
        cnt_d[i] = '0;
      end else if (chg_w[i] && (cnt_q[i] != SAT)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Readback mux: pre-update count of the selected channel, 0 for out-of-range selects.
  always_comb begin
    cnt_out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.sel == SW'(i)) cnt_out_d = cnt_q[i];
    end
  end

  // Counter array and readback register.
  // NOTE: the counter array is a handful of flops, not a RAM, so each entry is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      cnt_out_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      cnt_out_q <= cnt_out_d;
    end
  end

  assign bus.cnt_out = cnt_out_q;

`else

  // Counters are not built; the controls are deliberately left unused.
  logic unused_cfg;
  assign unused_cfg  = ^{bus.clr, bus.sel};
  assign bus.cnt_out = '0;

`endif

endmodule : cmp_latch_array

// File: tb/tb_cmp_latch_array.sv
// Self-checking bench for cmp_latch_array (CHANNELS=4, FILT_LEN=4, CNT_W=2).
// Directed scenarios (reset, latency, latch hold, glitch reject, counter
// saturation/clr, freeze, mid-run reset) followed by randomized traffic;
// every cycle is compared against a behavioural model.
module tb_cmp_latch_array;

  localparam int CH   = 4;
  localparam int FL   = 4;
  localparam int CW   = 2;
  localparam int SATV = (1 << CW) - 1;

  typedef logic [CH-1:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cmp_latch_array_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  cmp_latch_array #(
    .CHANNELS (CH),
    .FILT_LEN (FL),
    .CNT_W    (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Pins sampled at each edge; the decision logic sees them two edges later.
  vec_t hist_p[$];
  vec_t hist_n[$];
  vec_t m_out;
  vec_t m_chg;          // pulse scheduled for the cycle after a flip (before ena masking)
  int   m_run [CH];     // consecutive qualifying cycles seen so far
  int   m_cnt [CH];
  int   m_cnt_out;

  task automatic model_reset();
    hist_p.delete();
    hist_n.delete();
    m_out     = '0;
    m_chg     = '0;
    m_cnt_out = 0;
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    vec_t sp, sn, vis;
    int   sel_v;
    sp    = (hist_p.size() >= 2) ? hist_p[hist_p.size()-2] : '0;
    sn    = (hist_n.size() >= 2) ? hist_n[hist_n.size()-2] : '0;
    vis   = m_chg & {CH{bus.ena}};
    sel_v = int'(bus.sel);
    // counters and readback use the values before this edge
    m_cnt_out = (sel_v < CH) ? m_cnt[sel_v] : 0;
    for (int i = 0; i < CH; i++) begin
      if (bus.clr)     m_cnt[i] = 0;
      else if (vis[i]) m_cnt[i] = (m_cnt[i] + 1 > SATV) ? SATV : m_cnt[i] + 1;
    end
    // decision filter
    m_chg = '0;
    if (bus.ena) begin
      for (int i = 0; i < CH; i++) begin
        if (sp[i] != sn[i] && sp[i] != m_out[i]) begin
          m_run[i]++;
          if (m_run[i] == FL) begin
            m_out[i] = sp[i];
            m_chg[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    hist_p.push_back(bus.vip);
    hist_n.push_back(bus.vin);
    if (hist_p.size() > 3) void'(hist_p.pop_front());
    if (hist_n.size() > 3) void'(hist_n.pop_front());
  endtask

  task automatic compare_all();
    int exp_cnt;
`ifdef CMP_EVCNT_EN
    exp_cnt = m_cnt_out;
`else
    exp_cnt = 0;
`endif
    check("out",     32'(bus.out),     32'(m_out));
    check("chg",     32'(bus.chg),     32'(m_chg & {CH{bus.ena}}));
    check("cnt_out", 32'(bus.cnt_out), 32'(exp_cnt));
  endtask

  // Advance n clocks: model follows each rising edge, outputs compared on the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_edge();
      else       model_reset();
      @(negedge clk);
      compare_all();
    end
  endtask

  // Expected counter readback in this build.
  function automatic int cnt_exp(input int v);
`ifdef CMP_EVCNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  initial begin
    // 1. reset with pins asserting on every channel
    bus.ena = 1'b1;
    bus.clr = 1'b0;
    bus.sel = '0;
    bus.vip = '1;
    bus.vin = '0;
    model_reset();
    tick(3);
    check("rst_out", 32'(bus.out),     32'd0);
    check("rst_chg", 32'(bus.chg),     32'd0);
    check("rst_cnt", 32'(bus.cnt_out), 32'd0);
    bus.vip = '0;
    rst_n   = 1'b1;
    tick(4);

    // 2. latency: ch0 step held, decision and pulse exactly 6 clocks after the pin edge
    bus.vip[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (k < 6) check("lat_early", 32'(bus.out[0]), 32'd0);
      if (k == 6) begin
        check("lat_out", 32'(bus.out[0]), 32'd1);
        check("lat_chg", 32'(bus.chg[0]), 32'd1);
      end
      if (k == 7) check("lat_pulse", 32'(bus.chg[0]), 32'd0);
    end

    // 3. latch hold: ch1 set, then vip=vin=1 for 20 clocks
    bus.vip[1] = 1'b1;
    tick(8);
    check("hold_set", 32'(bus.out[1]), 32'd1);
    bus.vin[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("hold_out", 32'(bus.out[1]), 32'd1);
      check("hold_chg", 32'(bus.chg[1]), 32'd0);
    end

    // 4. glitch reject on ch2: 3 qualifying, 1 agreeing, 3 qualifying
    bus.vip[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(1); check("glitch", 32'(bus.out[2]), 32'd0); end
    bus.vip[2] = 1'b0;
    tick(1);
    check("glitch", 32'(bus.out[2]), 32'd0);
    bus.vip[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(1); check("glitch", 32'(bus.out[2]), 32'd0); end
    bus.vip[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(1); check("glitch", 32'(bus.out[2]), 32'd0); end

    // 5. five toggles on ch3 saturate a 2-bit counter, then clr against a chg
    bus.sel = 2'd3;
    for (int t = 0; t < 5; t++) begin
      bus.vip[3] = (t % 2 == 0);
      bus.vin[3] = (t % 2 != 0);
      tick(8);
    end
    tick(2);
    check("sat_cnt", 32'(bus.cnt_out), 32'(cnt_exp(3)));
    bus.vip[3] = 1'b0;
    bus.vin[3] = 1'b1;
    tick(6);
    check("clr_chg", 32'(bus.chg[3]), 32'd1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    tick(1);
    check("clr_cnt", 32'(bus.cnt_out), 32'd0);

    // 6a. freeze during a qualifying run on ch0
    bus.sel    = 2'd0;
    bus.vip[0] = 1'b0;
    bus.vin[0] = 1'b1;
    tick(4);
    bus.ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("frz_out", 32'(bus.out[0]), 32'd1);
      check("frz_chg", 32'(bus.chg),    32'd0);
    end
    bus.ena = 1'b1;
    tick(4);
    check("frz_done", 32'(bus.out[0]), 32'd0);
    tick(2);
    check("pre_rst_cnt", 32'(bus.cnt_out), 32'(cnt_exp(2)));

    // 6b. asynchronous reset in the middle of a run on ch1
    bus.vip[1] = 1'b0;
    bus.vin[1] = 1'b1;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 32'(bus.out),     32'd0);
    check("arst_chg", 32'(bus.chg),     32'd0);
    check("arst_cnt", 32'(bus.cnt_out), 32'd0);
    model_reset();
    tick(2);
    bus.vip = '0;
    bus.vin = '0;
    rst_n   = 1'b1;
    tick(3);

    // 7. randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          bus.vip[i] = 1'($urandom_range(0, 1));
          bus.vin[i] = 1'($urandom_range(0, 1));
        end
      end
      bus.ena = ($urandom_range(0, 9) != 0);
      bus.clr = ($urandom_range(0, 24) == 0);
      bus.sel = 2'($urandom_range(0, CH - 1));
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_cmp_latch_array
